// File: rtl/datapath_ctrl_if.sv
// rtl/datapath_ctrl_if.sv - instruction input and datapath control bundle for datapath_ctrl.
interface datapath_ctrl_if;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [15:0] datapath_in;
    logic        vsel;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;

    modport master (
        output in, load, s,
        input  w, datapath_in, vsel, writenum, write, readnum,
               loada, loadb, shift, asel, bsel, ALUop, loadc, loads
    );

    modport slave (
        input  in, load, s,
        output w, datapath_in, vsel, writenum, write, readnum,
               loada, loadb, shift, asel, bsel, ALUop, loadc, loads
    );
endinterface

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - instruction register and Moore FSM sequencing a register-file/ALU datapath.
module datapath_ctrl (
    input logic       clk,
    input logic       reset,
    datapath_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WR_REG, S_WR_IMM
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;

    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;
    logic [7:0] w_imm8;
    logic       w_mov_imm;
    logic       w_mov_reg;
    logic       w_alu_cls;
    logic       w_cmp;
    logic       w_uses_a;

    assign w_opcode  = r_ir[15:13];
    assign w_op      = r_ir[12:11];
    assign w_rn      = r_ir[10:8];
    assign w_rd      = r_ir[7:5];
    assign w_sh      = r_ir[4:3];
    assign w_rm      = r_ir[2:0];
    assign w_imm8    = r_ir[7:0];
    assign w_mov_imm = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_mov_reg = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_alu_cls = (w_opcode == 3'b101);
    assign w_cmp     = w_alu_cls && (w_op == 2'b01);
    // MVN is the only ALU-class op that ignores the A operand.
    assign w_uses_a  = w_alu_cls && (w_op != 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT && bus.load) begin
                r_ir <= bus.in;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.w           = 1'b0;
        bus.datapath_in = 16'h0000;
        bus.vsel        = 1'b0;
        bus.writenum    = 3'd0;
        bus.write       = 1'b0;
        bus.readnum     = 3'd0;
        bus.loada       = 1'b0;
        bus.loadb       = 1'b0;
        bus.shift       = 2'b00;
        bus.asel        = 1'b0;
        bus.bsel        = 1'b0;
        bus.ALUop       = 2'b00;
        bus.loadc       = 1'b0;
        bus.loads       = 1'b0;
        case (r_state)
            S_WAIT: begin
                bus.w = 1'b1;
                if (bus.s) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_mov_imm)                           w_next = S_WR_IMM;
                else if (w_mov_reg || (w_alu_cls && !w_uses_a)) w_next = S_GET_B;
                else if (w_alu_cls)                      w_next = S_GET_A;
                else                                     w_next = S_WAIT;
            end
            S_GET_A: begin
                bus.readnum = w_rn;
                bus.loada   = 1'b1;
                w_next      = S_GET_B;
            end
            S_GET_B: begin
                bus.readnum = w_rm;
                bus.loadb   = 1'b1;
                w_next      = S_ALU;
            end
            S_ALU: begin
                bus.shift = w_sh;
                bus.loadc = 1'b1;
                bus.loads = w_cmp;
                bus.asel  = !w_uses_a;
                bus.ALUop = w_mov_reg ? 2'b00 : w_op;
                w_next    = w_cmp ? S_WAIT : S_WR_REG;
            end
            S_WR_REG: begin
                bus.writenum = w_rd;
                bus.write    = 1'b1;
                w_next       = S_WAIT;
            end
            S_WR_IMM: begin
                bus.writenum    = w_rn;
                bus.vsel        = 1'b1;
                bus.write       = 1'b1;
                bus.datapath_in = {{8{w_imm8[7]}}, w_imm8};
                w_next          = S_WAIT;
            end
            default: w_next = S_WAIT;
        endcase
    end
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - self-checking bench for datapath_ctrl with an attached datapath and ISA model.
module tb_datapath_ctrl;
    typedef logic [34:0] vec_t;
    localparam vec_t IDLE = {1'b1, 34'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    datapath_ctrl_if bus();
    datapath_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int   errors = 0;
    int   checks = 0;
    vec_t exp_q[$];
    vec_t dut_vec;

    logic [15:0] dp_r [8] = '{default: 16'h0000};
    logic [15:0] ref_r [8] = '{default: 16'h0000};
    logic [15:0] dp_a = 16'h0;
    logic [15:0] dp_b = 16'h0;
    logic [15:0] dp_c = 16'h0;

    assign dut_vec = {bus.w, bus.datapath_in, bus.vsel, bus.writenum, bus.write, bus.readnum,
                      bus.loada, bus.loadb, bus.shift, bus.asel, bus.bsel, bus.ALUop,
                      bus.loadc, bus.loads};

    function automatic logic [15:0] shf(input logic [15:0] b, input logic [1:0] sh);
        case (sh)
            2'b00:   return b;
            2'b01:   return {b[14:0], 1'b0};
            2'b10:   return {1'b0, b[15:1]};
            default: return {b[15], b[15:1]};
        endcase
    endfunction

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return ~b;
        endcase
    endfunction

    // Datapath reacting to the controller strobes.
    always @(posedge clk) begin
        if (bus.loada) dp_a <= dp_r[bus.readnum];
        if (bus.loadb) dp_b <= dp_r[bus.readnum];
        if (bus.loadc) dp_c <= alu_f(bus.asel ? 16'h0 : dp_a, shf(dp_b, bus.shift), bus.ALUop);
        if (bus.write) dp_r[bus.writenum] <= bus.vsel ? bus.datapath_in : dp_c;
    end

    function automatic vec_t ov(input logic w, input logic [15:0] dpin, input logic vsel,
                                input logic [2:0] wn, input logic wr, input logic [2:0] rn,
                                input logic la, input logic lb, input logic [1:0] sh,
                                input logic asel, input logic [1:0] alu, input logic lc,
                                input logic ls);
        return {w, dpin, vsel, wn, wr, rn, la, lb, sh, asel, 1'b0, alu, lc, ls};
    endfunction

    // Per-cycle expected outputs from the edge that accepts s until ready again.
    task automatic build_exp(input logic [15:0] ir);
        logic is_imm, is_movr, is_alu, is_cmp, uses_a;
        is_imm  = ir[15:11] == 5'b11010;
        is_movr = ir[15:11] == 5'b11000;
        is_alu  = ir[15:13] == 3'b101;
        is_cmp  = is_alu && ir[12:11] == 2'b01;
        uses_a  = is_alu && ir[12:11] != 2'b11;
        exp_q = {};
        exp_q.push_back('0);
        if (is_imm) begin
            exp_q.push_back(ov(0, {{8{ir[7]}}, ir[7:0]}, 1, ir[10:8], 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end else if (is_movr || is_alu) begin
            if (uses_a) exp_q.push_back(ov(0, 0, 0, 0, 0, ir[10:8], 1, 0, 0, 0, 0, 0, 0));
            exp_q.push_back(ov(0, 0, 0, 0, 0, ir[2:0], 0, 1, 0, 0, 0, 0, 0));
            exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0, 0, ir[4:3], !uses_a,
                               is_movr ? 2'b00 : ir[12:11], 1, is_cmp));
            if (!is_cmp) exp_q.push_back(ov(0, 0, 0, ir[7:5], 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        exp_q.push_back(IDLE);
    endtask

    task automatic isa_exec(input logic [15:0] ir);
        logic [15:0] b;
        b = shf(ref_r[ir[2:0]], ir[4:3]);
        if (ir[15:11] == 5'b11010)      ref_r[ir[10:8]] = {{8{ir[7]}}, ir[7:0]};
        else if (ir[15:11] == 5'b11000) ref_r[ir[7:5]] = b;
        else if (ir[15:13] == 3'b101) begin
            case (ir[12:11])
                2'b00: ref_r[ir[7:5]] = ref_r[ir[10:8]] + b;
                2'b10: ref_r[ir[7:5]] = ref_r[ir[10:8]] & b;
                2'b11: ref_r[ir[7:5]] = ~b;
                default: ;
            endcase
        end
    endtask

    function automatic bit regs_match();
        for (int i = 0; i < 8; i++) if (dp_r[i] !== ref_r[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] gen_word();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 6))
            0:          w[15:11] = 5'b11010;
            1:          w[15:11] = 5'b11000;
            2, 3, 4, 5: w[15:13] = 3'b101;
            default: if (w[15:11] == 5'b11010 || w[15:11] == 5'b11000 || w[15:13] == 3'b101)
                         w[15:13] = 3'b111;
        endcase
        return w;
    endfunction

    // Called at a negedge while ready; returns at the negedge after s was sampled.
    task automatic issue(input logic [15:0] word, input logic do_load);
        bus.in = word; bus.load = do_load; bus.s = 1'b1;
        @(negedge clk);
        bus.load = 1'b0; bus.s = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.in = 16'($urandom); bus.load = 1'b1; bus.s = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dut_vec !== IDLE) begin
            errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, IDLE);
        end
        reset = 1'b0; bus.load = 1'b0; bus.s = 1'b0;
    endtask

    task automatic test_unsupported();
        build_exp(16'h0000);
        issue(16'h1234, 1'b0);
        foreach (exp_q[k]) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (dut_vec !== exp_q[k]) begin
                errors++; $display("FAIL unsupported_ir0 cyc%0d got=%h exp=%h", k, dut_vec, exp_q[k]);
            end
        end
    endtask

    task automatic test_directed();
        logic [15:0] words [5] = '{16'hD007, 16'hD3FF, 16'hD102, 16'hA148, 16'hA900};
        foreach (words[i]) begin
            build_exp(words[i]); isa_exec(words[i]);
            issue(words[i], 1'b1);
            foreach (exp_q[k]) begin
                if (k > 0) @(negedge clk);
                checks++;
                if (dut_vec !== exp_q[k]) begin
                    errors++; $display("FAIL directed ir=%h cyc%0d got=%h exp=%h", words[i], k, dut_vec, exp_q[k]);
                end
            end
        end
        checks++;
        if (dp_r[2] !== 16'd16) begin errors++; $display("FAIL add_r2 got=%0d exp=16", dp_r[2]); end
        checks++;
        if (dp_r[3] !== 16'hFFFF) begin errors++; $display("FAIL movimm_r3 got=%h exp=ffff", dp_r[3]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] word;
        repeat (60) begin
            word = gen_word();
            build_exp(word); isa_exec(word);
            issue(word, 1'b1);
            foreach (exp_q[k]) begin
                if (k > 0) @(negedge clk);
                checks++;
                if (dut_vec !== exp_q[k]) begin
                    errors++; $display("FAIL random ir=%h cyc%0d got=%h exp=%h", word, k, dut_vec, exp_q[k]);
                end
            end
            checks++;
            if (!regs_match()) begin
                errors++; $display("FAIL random_regs ir=%h got_r0=%h exp_r0=%h", word, dp_r[0], ref_r[0]);
            end
        end
    endtask

    task automatic test_load_ignored();
        logic [15:0] word;
        word = {5'b10100, 11'($urandom)};
        build_exp(word); isa_exec(word);
        issue(word, 1'b1);
        foreach (exp_q[k]) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (dut_vec !== exp_q[k]) begin
                errors++; $display("FAIL load_in_getb cyc%0d got=%h exp=%h", k, dut_vec, exp_q[k]);
            end
            bus.load = 1'b0; bus.s = 1'b0;
            if (k == 2) begin bus.in = 16'hD5AA; bus.load = 1'b1; bus.s = 1'b1; end
        end
        // Rerun without loading: IR must still hold the original word.
        isa_exec(word);
        issue(16'hD6AA, 1'b0);
        foreach (exp_q[k]) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (dut_vec !== exp_q[k]) begin
                errors++; $display("FAIL ir_kept cyc%0d got=%h exp=%h", k, dut_vec, exp_q[k]);
            end
        end
        checks++;
        if (!regs_match()) begin errors++; $display("FAIL ir_kept_regs got_r5=%h exp_r5=%h", dp_r[5], ref_r[5]); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] word;
        word = {5'b10100, 3'd1, 3'd4, 2'b00, 3'd1};
        build_exp(word);
        issue(word, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (dut_vec !== exp_q[k]) begin
                errors++; $display("FAIL pre_reset cyc%0d got=%h exp=%h", k, dut_vec, exp_q[k]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (dut_vec !== IDLE) begin errors++; $display("FAIL reset_in_alu got=%h exp=%h", dut_vec, IDLE); end
        @(negedge clk);
        checks++;
        if (!regs_match()) begin errors++; $display("FAIL reset_abort_regs got_r4=%h exp_r4=%h", dp_r[4], ref_r[4]); end
        checks++;
        if (dut_vec !== IDLE) begin errors++; $display("FAIL reset_stays_idle got=%h exp=%h", dut_vec, IDLE); end
    endtask

    initial begin
        bus.in = 16'h0; bus.load = 1'b0; bus.s = 1'b0;
        @(negedge clk);
        test_reset();
        test_unsupported();
        test_directed();
        test_back_to_back();
        test_load_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows, each listed as name, direction, width and meaning:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in  in  16  instruction word.
- load  in  1  capture `in` into the instruction register (IR).
- s  in  1  start execution of the IR.
- w  out  1  idle/ready flag.
- datapath_in  out  16  immediate value to the datapath.
- vsel  out  1  writeback mux select: 1 = datapath_in, 0 = C.
- writenum  out  3  register-file write index.
- write  out  1  register-file write enable.
- readnum  out  3  register-file read index.
- loada  out  1  load A register.
- loadb  out  1  load B register.
- shift  out  2  shifter control.
- asel  out  1  A operand select: 1 = zero, 0 = A.
- bsel  out  1  B operand select.
- ALUop  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT B.
- loadc  out  1  load C register.
- loads  out  1  load status register.

Function
REQ-003 The IR fields SHALL be decoded as:
- opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0], imm8 [7:0].
REQ-004 The supported instructions SHALL be:
- MOV Rn,#imm8 (110/10).
- MOV Rd,Rm{,sh} (110/00).
- ADD (101/00).
- CMP (101/01).
- AND (101/10).
- MVN (101/11).
REQ-005 The FSM states SHALL be WAIT, DECODE, GET_A, GET_B, ALU, WR_REG and WR_IMM.
REQ-006 All outputs SHALL be Moore outputs (a function of state and IR only); any output not listed for a state SHALL be 0.
REQ-007 WAIT:
- Outputs: w=1.
- Transition: s=1 -> DECODE; otherwise stay in WAIT.
REQ-008 DECODE:
- Outputs: none.
- Transitions: MOV imm -> WR_IMM; MOV reg or MVN -> GET_B; ADD, CMP or AND -> GET_A; any other opcode/op -> WAIT with no register write.
REQ-009 GET_A:
- Outputs: readnum=Rn, loada=1.
- Transition: -> GET_B.
REQ-010 GET_B:
- Outputs: readnum=Rm, loadb=1.
- Transition: -> ALU.
REQ-011 ALU:
- Outputs: shift=sh, bsel=0, loadc=1, loads=1 for CMP only.
- asel=1 for MOV reg and MVN; asel=0 otherwise.
- ALUop = 00 for MOV reg, otherwise ALUop = op.
- Transition: CMP -> WAIT; otherwise -> WR_REG.
REQ-012 WR_REG:
- Outputs: writenum=Rd, vsel=0, write=1.
- Transition: -> WAIT.
REQ-013 WR_IMM:
- Outputs: writenum=Rn, vsel=1, write=1, datapath_in = sign-extend(imm8) to 16 bits.
- Transition: -> WAIT.
REQ-014 In every state except WR_IMM, datapath_in SHALL be 16'h0000.
REQ-015 Latency, counted from the edge that samples s=1 in WAIT to w=1:
- MOV imm: 3 cycles.
- MOV reg and MVN: 5 cycles.
- CMP: 5 cycles.
- ADD and AND: 6 cycles.
- Unsupported instruction: 2 cycles.
REQ-016 The IR SHALL load only when load=1 while in WAIT; load SHALL be ignored in all other states.
REQ-017 When load=1 and s=1 arrive in the same WAIT cycle, the FSM SHALL execute the newly loaded word.
REQ-018 The s input SHALL be ignored outside WAIT; it SHALL have no effect when held high except to restart from WAIT.
REQ-019 Exactly one of write, loada, loadb or loadc SHALL be asserted per non-WAIT, non-DECODE cycle.
REQ-020 write SHALL never be asserted for CMP or for unsupported instructions.

Reset
REQ-021 When reset=1 at a clock edge, the block SHALL go to state WAIT with IR = 16'h0000, regardless of s or load.
REQ-022 After reset, outputs SHALL be w=1 with every other output 0.
REQ-023 Reset asserted mid-instruction SHALL abort the instruction: no write SHALL occur after the reset edge.
REQ-024 Reset SHALL take priority over load and s.

Verification
REQ-025 Load 16'hD007 and pulse s -> in WR_IMM, writenum=0, vsel=1, write=1 and datapath_in=16'd7; w=1 on the third edge.
REQ-026 Load 16'hD3FF -> in WR_IMM, writenum=3 and datapath_in=16'hFFFF.
REQ-027 Load 16'hA148 (ADD R2,R1,R0,LSL#1) -> the following sequence, with w returning after 6 cycles; with an attached datapath holding R0=7 and R1=2, R2 SHALL read 16:
- GET_A: readnum=1, loada=1.
- GET_B: readnum=0, loadb=1.
- ALU: shift=01, ALUop=00, loadc=1.
- WR_REG: writenum=2, write=1.
REQ-028 Load 16'hA900 (CMP) -> in ALU, ALUop=01 and loads=1; write SHALL stay 0 throughout; w returns after 5 cycles.
REQ-029 Load 16'h0000 and pulse s -> WAIT, DECODE, WAIT with all strobes 0.
REQ-030 Change `in` and pulse load during GET_B -> the IR SHALL be unchanged and execution SHALL complete on the original word.
REQ-031 Assert reset during ALU -> the block SHALL be in WAIT with w=1 next cycle, and no write SHALL be issued.
